input_cond: RTL
===============

INPUT_COND -- requirements
Module: input_cond

Interface
REQ-001 Parameter TICK_CYCLES, default 50000: clock cycles per debounce sample tick (1 ms at 50 MHz).
REQ-002 Parameter DB_TICKS, default 10: consecutive differing ticks required to accept a new level; legal range 1..15.
REQ-003 clk  input  1  system clock, 50 MHz; the only clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 key_n  input  4  raw push-buttons, active-low (0 = pressed), asynchronous to clk.
REQ-006 sw  input  18  raw slide switches, asynchronous to clk.
REQ-007 key_db  output  4  debounced buttons, active-high (1 = pressed).
REQ-008 key_press  output  4  one-cycle pulse per debounced press.
REQ-009 sw_db  output  18  debounced switches.
REQ-010 run  output  1  run/hold state for the downstream counter, toggled by button 1.
REQ-011 clr  output  1  counter clear request, equal to key_db[0].

Function
REQ-012 Each of the 22 raw inputs SHALL pass a 2-flop synchronizer; key_n is inverted after synchronization, giving s[i] with 1 = pressed/on.
REQ-013 A shared prescaler SHALL count 0..TICK_CYCLES-1 and wrap to 0; tick is high only in the cycle where the prescaler equals TICK_CYCLES-1.
REQ-014 Per input, a counter of width clog2(DB_TICKS+1) SHALL clear in any cycle where s[i] equals the stable output bit, regardless of tick.
REQ-015 When s[i] differs from the stable bit in a tick cycle, the counter SHALL increment; if the incremented value equals DB_TICKS, the stable bit SHALL take s[i] at that edge and the counter SHALL clear.
REQ-016 The counter SHALL never exceed DB_TICKS; there is no wrap.
REQ-017 Any bounce (s[i] equal to stable bit for one or more cycles) SHALL restart qualification from zero.
REQ-018 Latency from a clean raw edge to the output change SHALL be between (DB_TICKS-1)*TICK_CYCLES+3 and DB_TICKS*TICK_CYCLES+3 cycles inclusive.
REQ-019 key_press[i] SHALL be high exactly in the first cycle key_db[i] is 1, using a registered copy of key_db; no pulse on release.
REQ-020 Holding a button SHALL produce exactly one key_press pulse.
REQ-021 run SHALL invert on each cycle key_press[1] is high; it is unaffected by all other buttons.
REQ-022 Simultaneous presses on several buttons SHALL each produce an independent pulse in the same cycle.
REQ-023 All outputs SHALL be driven directly from flops, except key_press and clr, which are 2-input logic of flops.
REQ-024 Channels SHALL be fully independent; activity on one input SHALL never alter another input's counter.

Reset
REQ-025 When rst_n is low, all flops SHALL reset asynchronously: synchronizers to released/off (s = 0), prescaler 0, counters 0, key_db 0, sw_db 0, key_press 0, run 1, clr 0.
REQ-026 Reset asserted mid-qualification SHALL discard progress; after release, an input already held SHALL need a full DB_TICKS qualification before appearing.
REQ-027 Reset release SHALL be consumed synchronously; the first active edge after release SHALL behave as a normal cycle.

Verification (TICK_CYCLES=4, DB_TICKS=3)
REQ-028 Clean press: key_n[2] driven 1 to 0 and held -> key_db[2] rises within 11..15 cycles, key_press[2] is high for 1 cycle, run is unchanged.
REQ-029 Bounce: sw[5] toggles every 3 cycles for 40 cycles, then settles at 1 -> sw_db[5] stays 0 throughout the bouncing, then rises within 15 cycles of settling.
REQ-030 Run toggle: three separate debounced presses of key_n[1] -> run goes 1 to 0 to 1 to 0, with exactly 3 key_press[1] pulses in total.
REQ-031 Hold and release: key_n[0] held for 100 cycles, then released -> clr is high while held, exactly one key_press[0] pulse occurs, and clr falls within 15 cycles of release.
REQ-032 Reset mid-operation: rst_n pulsed low 6 cycles after key_n[3] is pressed, key still held -> all outputs take reset values immediately, and key_db[3] rises 11..15 cycles after rst_n goes high.
REQ-033 Simultaneous events: all four keys pressed in the same cycle -> key_press = 4'b1111 for one cycle and run toggles once.

Source files
------------

// File: rtl/input_cond.sv
// Input conditioning for push-buttons and slide switches: 2-flop synchronizers,
// tick-based debounce, press-edge pulses and a run/hold toggle on button 1.
module input_cond #(
  parameter int TICK_CYCLES = 50000,
  parameter int DB_TICKS    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_n,
  input  logic [17:0] sw,
  output logic [3:0]  key_db,
  output logic [3:0]  key_press,
  output logic [17:0] sw_db,
  output logic        run,
  output logic        clr
);

  localparam int NCH = 22;
  localparam int PW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CW  = $clog2(DB_TICKS + 1);
  // Key bits sit in [3:0] and are active-low, so their synchronizers reset high.
  localparam logic [NCH-1:0] SYNC_RST = 22'h00000F;

  logic [NCH-1:0] r_meta;
  logic [NCH-1:0] r_sync;
  logic [NCH-1:0] w_s;
  logic [PW-1:0]  r_presc;
  logic           w_tick;
  logic [NCH-1:0] r_stable;
  logic [3:0]     r_key_q;
  logic           r_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= SYNC_RST;
      r_sync <= SYNC_RST;
    end else begin
      r_meta <= {sw, key_n};
      r_sync <= r_meta;
    end
  end

  assign w_s = {r_sync[NCH-1:4], ~r_sync[3:0]};

  assign w_tick = (r_presc == PW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_presc <= '0;
    else if (w_tick)
      r_presc <= '0;
    else
      r_presc <= r_presc + 1'b1;
  end

  // Each channel qualifies independently; any cycle matching the stable level restarts it.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt       <= '0;
        r_stable[g] <= 1'b0;
      end else if (w_s[g] == r_stable[g]) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        if (r_cnt == CW'(DB_TICKS - 1)) begin
          r_stable[g] <= w_s[g];
          r_cnt       <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_q <= '0;
      r_run   <= 1'b1;
    end else begin
      r_key_q <= r_stable[3:0];
      if (key_press[1])
        r_run <= ~r_run;
    end
  end

  assign key_db    = r_stable[3:0];
  assign sw_db     = r_stable[NCH-1:4];
  assign key_press = r_stable[3:0] & ~r_key_q;
  assign run       = r_run;
  assign clr       = r_stable[0];

endmodule
